// File: rtl/param_register_file.sv
// Parameterised register file with a general bank R1..R(NREG), a scratch
// bank S1..S(NSCR), a shared per-register operation unit and a sequential
// bank-copy engine that moves one register per cycle between the banks.
module param_register_file #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 4,
  parameter int NSCR   = 4,
  parameter int BYPASS = 0,
  localparam int SELW  = $clog2(NREG + NSCR)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [NREG-1:0]  RegSel,
  input  logic [NSCR-1:0]  ScrSel,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  input  logic             CopyStart,
  input  logic             CopyDir,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT  = (NREG < NSCR) ? NREG : NSCR;
  localparam int IDXW = $clog2(CNT) + 1;
  localparam int NALL = NREG + NSCR;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idxNext;
  logic            r_dir;
  logic            w_dirNext;
  logic            r_done;
  logic            w_doneNext;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_scr  [NSCR];

  logic [NREG-1:0]  w_regEn;
  logic [NSCR-1:0]  w_scrEn;
  logic [WIDTH-1:0] w_fromR;
  logic [WIDTH-1:0] w_fromS;
  logic [WIDTH-1:0] w_all [NALL];
  logic [NALL-1:0]  w_allEn;
  logic             w_busy;
  logic             w_bypassOn;

  // Result of one FunSel operation applied to a single register value.
  function automatic logic [WIDTH-1:0] applyOp(input logic [2:0] f,
                                               input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] d);
    case (f)
      3'b000:  return v - WIDTH'(1);
      3'b001:  return v + WIDTH'(1);
      3'b010:  return d;
      3'b011:  return '0;
      3'b100:  return v << 1;
      3'b101:  return v >> 1;
      3'b110:  return (v << 1) | (v >> (WIDTH - 1));
      default: return v;
    endcase
  endfunction

  assign w_busy     = (r_state == COPY);
  assign w_bypassOn = (BYPASS != 0) && !w_busy && (FunSel == 3'b010);
  assign Busy       = w_busy;
  assign Done       = r_done;

  // Turn the active-low, MSB-first select vectors into per-register enables.
  always_comb begin
    w_regEn = '0;
    w_scrEn = '0;
    for (int j = 0; j < NREG; j++) w_regEn[j] = ~RegSel[NREG-1-j];
    for (int j = 0; j < NSCR; j++) w_scrEn[j] = ~ScrSel[NSCR-1-j];
  end

  // Pick the register at the current copy index from each bank.
  always_comb begin
    w_fromR = '0;
    w_fromS = '0;
    for (int j = 0; j < CNT; j++) begin
      if (r_idx == IDXW'(j)) begin
        w_fromR = r_regs[j];
        w_fromS = r_scr[j];
      end
    end
  end

  // Copy FSM next-state: latch direction on start, walk idx, pulse Done at the end.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_dirNext   = r_dir;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (CopyStart) begin
          w_stateNext = COPY;
          w_idxNext   = '0;
          w_dirNext   = CopyDir;
        end
      end
      COPY: begin
        w_idxNext = r_idx + IDXW'(1);
        if (r_idx == IDXW'(CNT - 1)) begin
          w_stateNext = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Copy FSM state register; reset aborts any copy without a Done pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_dir   <= w_dirNext;
      r_done  <= w_doneNext;
    end
  end

  // Register banks: reset clears, a copy moves one entry, otherwise FunSel on enabled registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int j = 0; j < NREG; j++) r_regs[j] <= '0;
      for (int j = 0; j < NSCR; j++) r_scr[j]  <= '0;
    end else if (w_busy) begin
      for (int j = 0; j < NREG; j++) begin
        if (j < CNT && r_dir && r_idx == IDXW'(j)) r_regs[j] <= w_fromS;
      end
      for (int j = 0; j < NSCR; j++) begin
        if (j < CNT && !r_dir && r_idx == IDXW'(j)) r_scr[j] <= w_fromR;
      end
    end else begin
      for (int j = 0; j < NREG; j++) begin
        if (w_regEn[j]) r_regs[j] <= applyOp(FunSel, r_regs[j], I);
      end
      for (int j = 0; j < NSCR; j++) begin
        if (w_scrEn[j]) r_scr[j] <= applyOp(FunSel, r_scr[j], I);
      end
    end
  end

  // Flatten both banks into one select space: R first, then S.
  always_comb begin
    for (int j = 0; j < NREG; j++) begin
      w_all[j]   = r_regs[j];
      w_allEn[j] = w_regEn[j];
    end
    for (int j = 0; j < NSCR; j++) begin
      w_all[NREG+j]   = r_scr[j];
      w_allEn[NREG+j] = w_scrEn[j];
    end
  end

  // Read port A; unmatched selects fall through to zero.
  always_comb begin
    OutA = '0;
    for (int k = 0; k < NALL; k++) begin
      if (OutASel == SELW'(k)) OutA = (w_bypassOn && w_allEn[k]) ? I : w_all[k];
    end
  end

  // Read port B; unmatched selects fall through to zero.
  always_comb begin
    OutB = '0;
    for (int k = 0; k < NALL; k++) begin
      if (OutBSel == SELW'(k)) OutB = (w_bypassOn && w_allEn[k]) ? I : w_all[k];
    end
  end

endmodule
